// File: rtl/clk_burst_sequencer.sv
// Burst sequencer in front of the programmable clock divider: latches a divider value,
// settles, then holds en high for N divided periods. Define CLK_BURST_CONTINUOUS_EN for free-run on count==0.
module clk_burst_sequencer #(
  parameter int DIV_W      = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_divider,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             abort,
  output logic [DIV_W-1:0] divider,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] periods_left
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] per_len, per_len_n;
  logic [DIV_W-1:0] phase, phase_n;
  logic [DIV_W-1:0] divider_n;
  logic [CNT_W-1:0] pl_n;
  logic [SW-1:0]    settle_cnt, settle_n;
  logic             en_n;
  logic             live;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      divider      <= '0;
      per_len      <= DIV_W'(1);
      phase        <= '0;
      periods_left <= '0;
      settle_cnt   <= '0;
      en           <= 1'b0;
      live         <= 1'b0;
    end else begin
      state        <= state_n;
      divider      <= divider_n;
      per_len      <= per_len_n;
      phase        <= phase_n;
      periods_left <= pl_n;
      settle_cnt   <= settle_n;
      en           <= en_n;
      live         <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    divider_n = divider;
    per_len_n = per_len;
    phase_n   = phase;
    pl_n      = periods_left;
    settle_n  = settle_cnt;
    en_n      = en;
    case (state)
      IDLE: begin
        en_n = 1'b0;
        if (cfg_valid && cfg_ready) begin
          divider_n = cfg_divider;
          // divide-by-0 and divide-by-1 both pass clk_in through: one cycle per period
          per_len_n = (cfg_divider <= DIV_W'(1)) ? DIV_W'(1) : cfg_divider;
          pl_n      = cfg_count;
          settle_n  = '0;
          phase_n   = '0;
`ifdef CLK_BURST_CONTINUOUS_EN
          state_n   = SETTLE;
`else
          state_n   = (cfg_count == '0) ? DONE : SETTLE;
`endif
        end
      end
      SETTLE: begin
        if (abort) begin
          en_n    = 1'b0;
          pl_n    = '0;
          state_n = DONE;
        end else if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
          en_n    = 1'b1;
          phase_n = DIV_W'(1);
          state_n = RUN;
        end else begin
          settle_n = settle_cnt + SW'(1);
        end
      end
      RUN: begin
        if (abort) begin
          en_n    = 1'b0;
          pl_n    = '0;
          state_n = DONE;
        end else if (phase == per_len) begin
          if (periods_left == CNT_W'(1)) begin
            en_n    = 1'b0;
            pl_n    = '0;
            state_n = DONE;
          end else begin
            // periods_left==0 here only in free-run; it stays at 0
            phase_n = DIV_W'(1);
            if (periods_left != '0) pl_n = periods_left - CNT_W'(1);
          end
        end else begin
          phase_n = phase + DIV_W'(1);
        end
      end
      DONE: begin
        en_n    = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cfg_ready = live && (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
